// File: rtl/scalar_mult_ctrl_pkg.sv
// Shared definitions for the double-and-add scalar multiplication sequencer:
// default width, FSM state encoding and the affine point record.
package scalar_mult_ctrl_pkg;

    localparam int unsigned N = 231;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_DBL    = 3'd2;
    localparam logic [2:0] ST_WAIT_D = 3'd3;
    localparam logic [2:0] ST_ADDCHK = 3'd4;
    localparam logic [2:0] ST_WAIT_A = 3'd5;
    localparam logic [2:0] ST_NEXT   = 3'd6;
    localparam logic [2:0] ST_FIN    = 3'd7;

    // Point record at the default width; the controller declares the same shape at its own n.
    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         inf;
    } point_t;

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P. Drives one point-engine operation at a
// time and resolves identity, order-2 and P/-P cases locally.
module scalar_mult_ctrl
    import scalar_mult_ctrl_pkg::*;
#(
    parameter int unsigned n = N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] k,
    input  logic [n-1:0] px,
    input  logic [n-1:0] py,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] qx,
    output logic [n-1:0] qy,
    output logic         q_inf,
    output logic         op_start,
    output logic         op_dbl,
    output logic [n-1:0] op_x1,
    output logic [n-1:0] op_y1,
    output logic [n-1:0] op_x2,
    output logic [n-1:0] op_y2,
    input  logic         op_done,
    input  logic [n-1:0] op_x3,
    input  logic [n-1:0] op_y3,
    input  logic         op_inf
);

    localparam int unsigned IW = (n > 1) ? $clog2(n) : 1;
    localparam logic [IW-1:0] IdxTop = IW'(n - 1);

    typedef struct packed {
        logic [n-1:0] x;
        logic [n-1:0] y;
        logic         inf;
    } acc_t;

    logic [2:0]    state_q, state_d;
    acc_t          acc_q, acc_d;
    logic [n-1:0]  k_q, k_d;
    logic [n-1:0]  px_q, px_d;
    logic [n-1:0]  py_q, py_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    logic [n-1:0]  qx_q, qx_d;
    logic [n-1:0]  qy_q, qy_d;
    logic          qinf_q, qinf_d;
    logic          op_start_q, op_start_d;
    logic          op_dbl_q, op_dbl_d;
    logic [n-1:0]  op_x1_q, op_x1_d;
    logic [n-1:0]  op_y1_q, op_y1_d;
    logic [n-1:0]  op_x2_q, op_x2_d;
    logic [n-1:0]  op_y2_q, op_y2_d;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        k_d        = k_q;
        px_d       = px_q;
        py_d       = py_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        qx_d       = qx_q;
        qy_d       = qy_q;
        qinf_d     = qinf_q;
        op_start_d = 1'b0;
        op_dbl_d   = op_dbl_q;
        op_x1_d    = op_x1_q;
        op_y1_d    = op_y1_q;
        op_x2_d    = op_x2_q;
        op_y2_d    = op_y2_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d       = k;
                    px_d      = px;
                    py_d      = py;
                    idx_d     = IdxTop;
                    acc_d.inf = 1'b1;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (k_q[idx_q]) begin
                    acc_d = '{x: px_q, y: py_q, inf: 1'b0};
                    if (idx_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ST_DBL;
                    end
                end else if (idx_q == '0) begin
                    acc_d.inf = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DBL: begin
                if (acc_q.inf) begin
                    state_d = ST_ADDCHK;
                end else if (acc_q.y == '0) begin
                    // Tangent is vertical: doubling an order-2 point gives infinity.
                    acc_d.inf = 1'b1;
                    state_d   = ST_ADDCHK;
                end else begin
                    op_start_d = 1'b1;
                    op_dbl_d   = 1'b1;
                    op_x1_d    = acc_q.x;
                    op_y1_d    = acc_q.y;
                    state_d    = ST_WAIT_D;
                end
            end
            ST_WAIT_D: begin
                if (op_done) begin
                    acc_d   = '{x: op_x3, y: op_y3, inf: op_inf};
                    state_d = ST_ADDCHK;
                end
            end
            ST_ADDCHK: begin
                if (!k_q[idx_q]) begin
                    state_d = ST_NEXT;
                end else if (acc_q.inf) begin
                    acc_d   = '{x: px_q, y: py_q, inf: 1'b0};
                    state_d = ST_NEXT;
                end else if (acc_q.x == px_q) begin
                    // The engine's add reports equal-x as infinity, so P+P must go as a double.
                    if (acc_q.y == py_q) begin
                        op_start_d = 1'b1;
                        op_dbl_d   = 1'b1;
                        op_x1_d    = acc_q.x;
                        op_y1_d    = acc_q.y;
                        state_d    = ST_WAIT_A;
                    end else begin
                        acc_d.inf = 1'b1;
                        state_d   = ST_NEXT;
                    end
                end else begin
                    op_start_d = 1'b1;
                    op_dbl_d   = 1'b0;
                    op_x1_d    = acc_q.x;
                    op_y1_d    = acc_q.y;
                    op_x2_d    = px_q;
                    op_y2_d    = py_q;
                    state_d    = ST_WAIT_A;
                end
            end
            ST_WAIT_A: begin
                if (op_done) begin
                    acc_d   = '{x: op_x3, y: op_y3, inf: op_inf};
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = ST_DBL;
                end
            end
            ST_FIN: begin
                qx_d    = acc_q.inf ? '0 : acc_q.x;
                qy_d    = acc_q.inf ? '0 : acc_q.y;
                qinf_d  = acc_q.inf;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            k_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            qx_q       <= '0;
            qy_q       <= '0;
            qinf_q     <= 1'b0;
            op_start_q <= 1'b0;
            op_dbl_q   <= 1'b0;
            op_x1_q    <= '0;
            op_y1_q    <= '0;
            op_x2_q    <= '0;
            op_y2_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            px_q       <= px_d;
            py_q       <= py_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            qx_q       <= qx_d;
            qy_q       <= qy_d;
            qinf_q     <= qinf_d;
            op_start_q <= op_start_d;
            op_dbl_q   <= op_dbl_d;
            op_x1_q    <= op_x1_d;
            op_y1_q    <= op_y1_d;
            op_x2_q    <= op_x2_d;
            op_y2_q    <= op_y2_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign qx       = qx_q;
    assign qy       = qy_q;
    assign q_inf    = qinf_q;
    assign op_start = op_start_q;
    assign op_dbl   = op_dbl_q;
    assign op_x1    = op_x1_q;
    assign op_y1    = op_y1_q;
    assign op_x2    = op_x2_q;
    assign op_y2    = op_y2_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl on y^2 = x^3 + 2x + 2 mod 17 with P = (5,1), order 19,
// backed by a 3-cycle behavioural point engine.
module tb_scalar_mult_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] k, px, py;
    logic         busy, done, q_inf, op_start, op_dbl, op_done, op_inf;
    logic [W-1:0] qx, qy, op_x1, op_y1, op_x2, op_y2, op_x3, op_y3;

    logic eng_done = 1'b0;
    logic stray_op = 1'b0;
    assign op_done = eng_done | stray_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scalar_mult_ctrl #(.n(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .k        (k),
        .px       (px),
        .py       (py),
        .busy     (busy),
        .done     (done),
        .qx       (qx),
        .qy       (qy),
        .q_inf    (q_inf),
        .op_start (op_start),
        .op_dbl   (op_dbl),
        .op_x1    (op_x1),
        .op_y1    (op_y1),
        .op_x2    (op_x2),
        .op_y2    (op_y2),
        .op_done  (op_done),
        .op_x3    (op_x3),
        .op_y3    (op_y3),
        .op_inf   (op_inf)
    );

    function automatic int md(input int v);
        return ((v % 17) + 17) % 17;
    endfunction

    function automatic int inv(input int a);
        int r = 1;
        for (int i = 0; i < 15; i++) r = md(r * a);
        return r;
    endfunction

    // Behavioural engine, driven on the falling edge.
    bit           eng_busy = 1'b0;
    int           eng_cnt  = 0;
    logic [W-1:0] c_x1, c_y1, c_x2, c_y2;
    logic         c_dbl;
    int           n_dbl = 0, n_add = 0, stab_err = 0, ovl_err = 0;
    logic [15:0]  seq = '0;
    int           lam, rx, ry;
    logic         rinf;

    always @(negedge clk) begin
        if (!reset) begin
            eng_busy = 1'b0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (op_start) begin
                if (eng_busy) ovl_err++;
                c_x1 = op_x1; c_y1 = op_y1; c_x2 = op_x2; c_y2 = op_y2; c_dbl = op_dbl;
                seq = {seq[14:0], op_dbl};
                if (op_dbl) n_dbl++; else n_add++;
                eng_busy = 1'b1;
                eng_cnt  = 3;
            end else if (eng_busy) begin
                if (op_dbl !== c_dbl || op_x1 !== c_x1 || op_y1 !== c_y1 ||
                    (!c_dbl && (op_x2 !== c_x2 || op_y2 !== c_y2))) stab_err++;
                eng_cnt--;
                if (eng_cnt == 0) begin
                    rinf = 1'b0; rx = 0; ry = 0;
                    if (c_dbl) begin
                        if (c_y1 == 0) rinf = 1'b1;
                        else begin
                            lam = md((3 * int'(c_x1) * int'(c_x1) + 2) * inv(md(2 * int'(c_y1))));
                            rx  = md(lam * lam - 2 * int'(c_x1));
                            ry  = md(lam * (int'(c_x1) - rx) - int'(c_y1));
                        end
                    end else if (c_x1 == c_x2) begin
                        rinf = 1'b1;
                    end else begin
                        lam = md((int'(c_y2) - int'(c_y1)) * inv(md(int'(c_x2) - int'(c_x1))));
                        rx  = md(lam * lam - int'(c_x1) - int'(c_x2));
                        ry  = md(lam * (int'(c_x1) - rx) - int'(c_y1));
                    end
                    op_x3    = rx[W-1:0];
                    op_y3    = ry[W-1:0];
                    op_inf   = rinf;
                    eng_done = 1'b1;
                    eng_busy = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_k(input string tag, input logic [W-1:0] kk, input int ex, input int ey,
                         input logic einf, input int edbl, input int eadd, input bit poke);
        int d0 = n_dbl;
        int a0 = n_add;
        int s0 = stab_err;
        int v0 = ovl_err;
        bit got = 1'b0;
        @(negedge clk); start = 1'b1; k = kk; px = 8'd5; py = 8'd1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (poke) begin
            repeat (3) @(negedge clk);
            start = 1'b1; k = 8'd1; px = 8'd0; py = 8'd0;
            @(negedge clk); start = 1'b0;
        end
        for (int c = 0; c < 400 && !got; c++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_qx"}, 32'(qx), 32'(ex));
        check({tag, "_qy"}, 32'(qy), 32'(ey));
        check({tag, "_qinf"}, 32'(q_inf), 32'(einf));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_ndbl"}, 32'(n_dbl - d0), 32'(edbl));
        check({tag, "_nadd"}, 32'(n_add - a0), 32'(eadd));
        check({tag, "_stable"}, 32'(stab_err - s0), 32'd0);
        check({tag, "_overlap"}, 32'(ovl_err - v0), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit got;
        reset = 1'b0; start = 1'b0; k = '0; px = '0; py = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_opstart", 32'(op_start), 32'd0);
        check("rst_qx", 32'(qx), 32'd0);
        check("rst_qinf", 32'(q_inf), 32'd0);
        reset = 1'b1;

        run_k("k0", 8'd0, 0, 0, 1'b1, 0, 0, 1'b0);
        run_k("k1", 8'd1, 5, 1, 1'b0, 0, 0, 1'b0);
        run_k("k2", 8'd2, 6, 3, 1'b0, 1, 0, 1'b0);
        check("k2_opx1", 32'(c_x1), 32'd5);
        check("k2_opy1", 32'(c_y1), 32'd1);
        run_k("k5", 8'd5, 9, 16, 1'b0, 2, 1, 1'b0);
        check("k5_seq", 32'(seq[2:0]), 32'b110);
        run_k("k19", 8'd19, 0, 0, 1'b1, 4, 1, 1'b0);
        run_k("k5_poke", 8'd5, 9, 16, 1'b0, 2, 1, 1'b1);

        // Abort in WAIT_D.
        @(negedge clk); start = 1'b1; k = 8'd2; px = 8'd5; py = 8'd1;
        @(negedge clk); start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (op_start) got = 1'b1;
            else @(negedge clk);
        end
        check("abort_opstart", 32'(got), 32'd1);
        @(negedge clk);
        check("abort_waitd_busy", 32'(busy), 32'd1);
        check("abort_waitd_x1", 32'(op_x1), 32'd5);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_opdbl", 32'(op_dbl), 32'd0);
        check("abort_opx1", 32'(op_x1), 32'd0);
        check("abort_opy1", 32'(op_y1), 32'd0);
        check("abort_opx2", 32'(op_x2), 32'd0);
        check("abort_qx", 32'(qx), 32'd0);
        check("abort_qy", 32'(qy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); stray_op = 1'b1;
        @(negedge clk); stray_op = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_done", 32'(done), 32'd0);
        check("stray_opstart", 32'(op_start), 32'd0);
        check("stray_qx", 32'(qx), 32'd0);

        run_k("k5_after", 8'd5, 9, 16, 1'b0, 2, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
Sequencer for left-to-right double-and-add scalar multiplication Q = k·P over GF(p). Sits directly upstream of the point-operation engine (point addition / point doubling units behind one op interface). It issues one group operation at a time and consumes each result. It also resolves every identity/special case itself, because the addition engine reports equal-x inputs as infinity.

Parameters:
n, 231, field/scalar width in bits.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
k  in  n  scalar; latched on accepted start.
px  in  n  base point x; latched on accepted start.
py  in  n  base point y; latched on accepted start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse; qx/qy/q_inf are valid from this cycle.
qx  out  n  result x; held until the next accepted start.
qy  out  n  result y; held until the next accepted start.
q_inf  out  1  result is the point at infinity.
op_start  out  1  one-cycle pulse requesting an engine operation.
op_dbl  out  1  1 = double (x1,y1); 0 = add (x1,y1)+(x2,y2).
op_x1, op_y1, op_x2, op_y2  out  n each  engine operands.
op_done  in  1  engine result-valid pulse.
op_x3, op_y3  in  n each  engine result.
op_inf  in  1  engine result is infinity.

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, op_start, op_dbl, q_inf = 0; qx, qy and all op_* operands = 0.
- Internal state: acc (ax, ay, a_inf), latched k, P, bit index i (log2 n bits).
- IDLE: on start=1, latch k/px/py, set i=n-1, a_inf=1, go to SCAN. start in any other state is ignored.
- SCAN: test one bit per cycle.
  - k[i]=0 and i>0: i-1.
  - k[i]=1: acc=P, a_inf=0. If i=0, go to FIN; else i-1 and go to DBL.
  - k[i]=0 and i=0 (k=0): go to FIN with a_inf=1.
- DBL: step for bit i.
  - If a_inf=1, skip doubling and go to ADDCHK.
  - Else if ay=0, set a_inf=1 (order-2 point) and go to ADDCHK.
  - Else pulse op_start with op_dbl=1, op_x1/op_y1=acc, then WAIT_D.
- WAIT_D: on op_done, acc={op_x3,op_y3,op_inf}, then ADDCHK.
- ADDCHK:
  - k[i]=0: go to NEXT.
  - a_inf=1: acc=P, go to NEXT.
  - ax==px and ay==py: pulse op_start with op_dbl=1 on acc, then WAIT_A.
  - ax==px and ay!=py: a_inf=1, go to NEXT. No engine op.
  - Otherwise: pulse op_start with op_dbl=0, x1/y1=acc, x2/y2=P, then WAIT_A.
- WAIT_A: on op_done, load acc as in WAIT_D, then NEXT.
- NEXT: if i==0 go to FIN; else i-1 and go to DBL.
- FIN: qx/qy = acc coordinates, or 0/0 when a_inf=1; q_inf=a_inf; done=1 for one cycle; busy=0; return to IDLE.
- Engine handshake:
  - Operands and op_dbl are driven the cycle op_start pulses and held stable until op_done.
  - At most one operation is outstanding.
  - op_done outside WAIT_D/WAIT_A is ignored.
  - op_done in the same cycle as op_start cannot occur. The earliest accepted op_done is the cycle after op_start.
- Latency: (n - msb_index) SCAN cycles, plus 2–3 control cycles per processed bit, plus engine time. Engine op count = (bitlength-1) doublings + (popcount-1) additions, minus skipped identity cases.
- Reset during a WAIT state aborts the operation. A late op_done after reset is ignored (controller is in IDLE).

Decomposition:
- Shared package holds:
  - state encoding enum: IDLE, SCAN, DBL, WAIT_D, ADDCHK, WAIT_A, NEXT, FIN
  - parameter n default
  - a point-record typedef {x, y, inf}
- No sub-module. A single always_ff FSM with a combinational next-state/operand block is natural.
- The bench supplies a behavioural engine model.

Test Plan:
Bench uses a toy curve y²=x³+2x+2 mod 17, P=(5,1), order 19, n=8, and an engine model with 3-cycle latency.
- k=0 -> done pulse with q_inf=1, qx=qy=0, and zero op_start pulses.
- k=1 -> Q=(5,1), q_inf=0, zero engine operations.
- k=2 -> one DBL op with operands (5,1), Q=(6,3).
- k=5 (101b) -> op sequence DBL, DBL, ADD, Q=(9,16); operands stable for every cycle between op_start and op_done.
- k=19 -> final ADDCHK sees acc=18P=(5,16) and P=(5,1). No engine add is issued; q_inf=1.
- Sequence check, reset and restart:
  - start k=5, assert start again while busy -> ignored; same Q as a single start.
  - Pull reset low during WAIT_D -> all outputs zero immediately.
  - Feed a stray op_done after reset -> ignored.
  - A fresh start after reset completes correctly.
